decode_stage: RTL

- Registered RV32I decode stage between fetch and execute.
- Contains a parametrised instruction buffer (FIFO), a combinational decode core, and an ID/EX output register with valid/ready handshakes.
- Inserts one bubble on load-use hazards, supports flush on redirect, and flags illegal instructions.
- Optionally decodes the RV32M extension.

---
 rtl/decode_stage_pkg.sv | 77 +++++++
 rtl/decode_core.sv | 126 ++++++++++++
 rtl/decode_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared definitions for the RV32I decode stage: opcodes, instruction match
// patterns (including the RV32M group), control-field encodings and a helper
// that maps funct3 to an ALU operation.
// All "don't care" codes (ALU_X, RS1_X, RS2_X, WB_X, BR_X) are zero so that a
// reset ID/EX register reads as an all-zero bundle.
// Optional feature macro used by the decoder: DECODE_M_EXT_EN.
// ---------------------------------------------------------------------------
package decode_stage_pkg;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Match patterns: (inst & MASK) == MATCH
  localparam logic [31:0] MASK_F3_OP  = 32'h0000_707F;
  localparam logic [31:0] MATCH_LW    = 32'h0000_2003;
  localparam logic [31:0] MATCH_SW    = 32'h0000_2023;
  localparam logic [31:0] MATCH_JALR  = 32'h0000_0067;
  localparam logic [31:0] MASK_F7_OP  = 32'hFE00_007F;
  localparam logic [31:0] MATCH_M_EXT = 32'h0200_0033;

  typedef enum logic [4:0] {
    ALU_X    = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SLL  = 5'd3,
    ALU_SLT  = 5'd4,
    ALU_SLTU = 5'd5,
    ALU_XOR  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_OR   = 5'd9,
    ALU_AND  = 5'd10,
    ALU_JALR = 5'd11,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_fn_e;

  typedef enum logic [1:0] {RS1_X = 2'd0, RS1_RS1 = 2'd1, RS1_PC  = 2'd2} rs1_sel_e;
  typedef enum logic [1:0] {RS2_X = 2'd0, RS2_RS2 = 2'd1, RS2_IMM = 2'd2} rs2_sel_e;
  typedef enum logic       {MEN_0 = 1'b0, MEN_1 = 1'b1} men_e;
  typedef enum logic [1:0] {WB_X = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC = 2'd3} wb_sel_e;
  typedef enum logic [2:0] {
    BR_X = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
    BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6, BR_JAL = 3'd7
  } br_e;

  // funct3 -> ALU op for OP/OP-IMM; alt selects SUB/SRA (inst[30]).
  function automatic alu_fn_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_core.sv
// ---------------------------------------------------------------------------
// decode_core
// Purely combinational RV32I decoder (RV32M when DECODE_M_EXT_EN is defined).
// Ports:
//   i_inst        instruction word
//   o_imm         sign-extended immediate (0 for R-type / illegal)
//   o_rs1/rs2/rd  raw register fields inst[19:15], inst[24:20], inst[11:7]
//   o_alu_fn, o_rs1_sel, o_rs2_sel, o_mem_wen, o_wb_sel, o_br  control fields
//   o_illegal     encoding not recognised
//   o_uses_rs1/2  register sources actually read (for hazard detection)
// ---------------------------------------------------------------------------
module decode_core
  import decode_stage_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_alu_fn,
  output logic [1:0]  o_rs1_sel,
  output logic [1:0]  o_rs2_sel,
  output logic        o_mem_wen,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_br,
  output logic        o_illegal,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign o_rd     = i_inst[11:7];

  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  always_comb begin
    o_imm      = '0;
    o_alu_fn   = ALU_X;
    o_rs1_sel  = RS1_X;
    o_rs2_sel  = RS2_X;
    o_mem_wen  = MEN_0;
    o_wb_sel   = WB_X;
    o_br       = BR_X;
    o_illegal  = 1'b1;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_LOAD: if ((i_inst & MASK_F3_OP) == MATCH_LW) begin
        o_imm = w_imm_i; o_alu_fn = ALU_ADD; o_rs1_sel = RS1_RS1; o_rs2_sel = RS2_IMM;
        o_wb_sel = WB_MEM; o_illegal = 1'b0; o_uses_rs1 = 1'b1;
      end
      OP_STORE: if ((i_inst & MASK_F3_OP) == MATCH_SW) begin
        o_imm = w_imm_s; o_alu_fn = ALU_ADD; o_rs1_sel = RS1_RS1; o_rs2_sel = RS2_IMM;
        o_mem_wen = MEN_1; o_illegal = 1'b0; o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1;
      end
      OP_OP: begin
        // funct7=0100000 is only valid for SUB and SRA
        if (w_f7 == 7'b0000000 ||
            (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          o_alu_fn = alu_from_f3(w_f3, i_inst[30]); o_rs1_sel = RS1_RS1; o_rs2_sel = RS2_RS2;
          o_wb_sel = WB_ALU; o_illegal = 1'b0; o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1;
        end else if ((i_inst & MASK_F7_OP) == MATCH_M_EXT) begin
`ifdef DECODE_M_EXT_EN
          // funct3 order matches MUL..REMU, so the code is a plain offset
          o_alu_fn = ALU_MUL + {2'b00, w_f3}; o_rs1_sel = RS1_RS1; o_rs2_sel = RS2_RS2;
          o_wb_sel = WB_ALU; o_illegal = 1'b0; o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1;
`else
          o_illegal = 1'b1;
`endif
        end
      end
      OP_IMM: begin
        // shifts carry funct7 in the immediate field and must be well-formed
        if ((w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
            (w_f3 == 3'b101) ? (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) : 1'b1) begin
          o_imm = w_imm_i; o_alu_fn = alu_from_f3(w_f3, (w_f3 == 3'b101) && i_inst[30]);
          o_rs1_sel = RS1_RS1; o_rs2_sel = RS2_IMM; o_wb_sel = WB_ALU;
          o_illegal = 1'b0; o_uses_rs1 = 1'b1;
        end
      end
      OP_BRANCH: if (w_f3[2:1] != 2'b01) begin
        o_imm = w_imm_b; o_alu_fn = ALU_ADD; o_rs1_sel = RS1_PC; o_rs2_sel = RS2_IMM;
        o_illegal = 1'b0; o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1;
        case (w_f3)
          3'b000:  o_br = BR_EQ;
          3'b001:  o_br = BR_NE;
          3'b100:  o_br = BR_LT;
          3'b101:  o_br = BR_GE;
          3'b110:  o_br = BR_LTU;
          default: o_br = BR_GEU;
        endcase
      end
      OP_JAL: begin
        o_imm = w_imm_j; o_alu_fn = ALU_ADD; o_rs1_sel = RS1_PC; o_rs2_sel = RS2_IMM;
        o_wb_sel = WB_PC; o_br = BR_JAL; o_illegal = 1'b0;
      end
      OP_JALR: if ((i_inst & MASK_F3_OP) == MATCH_JALR) begin
        o_imm = w_imm_i; o_alu_fn = ALU_JALR; o_rs1_sel = RS1_RS1; o_rs2_sel = RS2_IMM;
        o_wb_sel = WB_PC; o_br = BR_JAL; o_illegal = 1'b0; o_uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        o_imm = w_imm_u; o_alu_fn = ALU_ADD; o_rs2_sel = RS2_IMM;
        o_wb_sel = WB_ALU; o_illegal = 1'b0;
      end
      OP_AUIPC: begin
        o_imm = w_imm_u; o_alu_fn = ALU_ADD; o_rs1_sel = RS1_PC; o_rs2_sel = RS2_IMM;
        o_wb_sel = WB_ALU; o_illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode stage: instruction buffer (circular FIFO), decode of
// the buffer head, load-use hazard bubble, flush, and ID/EX output register.
// Optional RV32M decode: define DECODE_M_EXT_EN.
// Ports:
//   clk, rst (async, active-high), flush (drop everything in flight)
//   if_valid/if_ready/if_inst/if_pc   fetch-side handshake
//   ex_ready                          execute accepts ID/EX contents
//   id_*                              registered decoded instruction
//   ibuf_count                        buffer occupancy
// ---------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IBUF_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        if_valid,
  output logic                        if_ready,
  input  logic [31:0]                 if_inst,
  input  logic [XLEN-1:0]             if_pc,
  input  logic                        ex_ready,
  output logic                        id_valid,
  output logic [XLEN-1:0]             id_pc,
  output logic [31:0]                 id_imm,
  output logic [4:0]                  id_rs1_addr,
  output logic [4:0]                  id_rs2_addr,
  output logic [4:0]                  id_rd_addr,
  output logic [4:0]                  id_alu_fn,
  output logic [1:0]                  id_rs1_sel,
  output logic [1:0]                  id_rs2_sel,
  output logic                        id_mem_wen,
  output logic [1:0]                  id_wb_sel,
  output logic [2:0]                  id_br,
  output logic                        id_illegal,
  output logic [$clog2(IBUF_DEPTH):0] ibuf_count
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [PTR_W:0] PTR_FULL = IBUF_DEPTH;

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage: only XLEN=32 is supported");
  end
  if (IBUF_DEPTH < 2 || (IBUF_DEPTH & (IBUF_DEPTH - 1)) != 0) begin : g_depth_check
    $error("decode_stage: IBUF_DEPTH must be a power of two >= 2");
  end

  // Buffer storage and pointers (extra MSB distinguishes full from empty)
  logic [31:0]     r_ibuf_inst [IBUF_DEPTH];
  logic [XLEN-1:0] r_ibuf_pc   [IBUF_DEPTH];
  logic [PTR_W:0]  r_wptr, r_rptr;

  logic [PTR_W:0]  w_count;
  logic            w_full, w_head_valid, w_push, w_pop, w_advance, w_hazard;
  logic [31:0]     w_head_inst;
  logic [XLEN-1:0] w_head_pc;

  // Decoded head
  logic [31:0] w_dec_imm;
  logic [4:0]  w_dec_rs1, w_dec_rs2, w_dec_rd, w_dec_alu_fn;
  logic [1:0]  w_dec_rs1_sel, w_dec_rs2_sel, w_dec_wb_sel;
  logic        w_dec_mem_wen, w_dec_illegal, w_uses_rs1, w_uses_rs2;
  logic [2:0]  w_dec_br;

  // ID/EX register
  logic            r_id_valid, r_id_mem_wen, r_id_illegal;
  logic [XLEN-1:0] r_id_pc;
  logic [31:0]     r_id_imm;
  logic [4:0]      r_id_rs1, r_id_rs2, r_id_rd, r_id_alu_fn;
  logic [1:0]      r_id_rs1_sel, r_id_rs2_sel, r_id_wb_sel;
  logic [2:0]      r_id_br;

  assign w_count      = r_wptr - r_rptr;
  assign w_full       = (w_count == PTR_FULL);
  assign w_head_valid = (r_wptr != r_rptr);
  assign w_head_inst  = r_ibuf_inst[r_rptr[PTR_W-1:0]];
  assign w_head_pc    = r_ibuf_pc[r_rptr[PTR_W-1:0]];

  // Not qualified by a same-cycle pop, keeping the fetch path short
  assign if_ready = !rst && !w_full && !flush;
  assign w_push   = if_valid && if_ready;

  decode_core u_core (
    .i_inst     (w_head_inst),
    .o_imm      (w_dec_imm),
    .o_rs1      (w_dec_rs1),
    .o_rs2      (w_dec_rs2),
    .o_rd       (w_dec_rd),
    .o_alu_fn   (w_dec_alu_fn),
    .o_rs1_sel  (w_dec_rs1_sel),
    .o_rs2_sel  (w_dec_rs2_sel),
    .o_mem_wen  (w_dec_mem_wen),
    .o_wb_sel   (w_dec_wb_sel),
    .o_br       (w_dec_br),
    .o_illegal  (w_dec_illegal),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2)
  );

  // Load in ID/EX whose destination is read by the head: hold the head a cycle
  assign w_advance = !r_id_valid || ex_ready;
  assign w_hazard  = r_id_valid && (r_id_wb_sel == WB_MEM) && (r_id_rd != 5'd0) &&
                     w_head_valid &&
                     ((w_uses_rs1 && (w_dec_rs1 == r_id_rd)) ||
                      (w_uses_rs2 && (w_dec_rs2 == r_id_rd)));
  assign w_pop     = !flush && w_advance && !w_hazard && w_head_valid;

  // Buffer pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Entry storage; stale contents are unreachable once the pointers reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ibuf_inst[r_wptr[PTR_W-1:0]] <= if_inst;
      r_ibuf_pc[r_wptr[PTR_W-1:0]]   <= if_pc;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_imm     <= '0;
      r_id_rs1     <= '0;
      r_id_rs2     <= '0;
      r_id_rd      <= '0;
      r_id_alu_fn  <= ALU_X;
      r_id_rs1_sel <= RS1_X;
      r_id_rs2_sel <= RS2_X;
      r_id_mem_wen <= MEN_0;
      r_id_wb_sel  <= WB_X;
      r_id_br      <= BR_X;
      r_id_illegal <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_pop) begin
        r_id_valid   <= 1'b1;
        r_id_pc      <= w_head_pc;
        r_id_imm     <= w_dec_imm;
        r_id_rs1     <= w_dec_rs1;
        r_id_rs2     <= w_dec_rs2;
        r_id_rd      <= w_dec_rd;
        r_id_alu_fn  <= w_dec_alu_fn;
        r_id_rs1_sel <= w_dec_rs1_sel;
        r_id_rs2_sel <= w_dec_rs2_sel;
        r_id_mem_wen <= w_dec_mem_wen;
        r_id_wb_sel  <= w_dec_wb_sel;
        r_id_br      <= w_dec_br;
        r_id_illegal <= w_dec_illegal;
      end else begin
        // hazard bubble or empty buffer
        r_id_valid <= 1'b0;
      end
    end
  end

  assign id_valid    = r_id_valid;
  assign id_pc       = r_id_pc;
  assign id_imm      = r_id_imm;
  assign id_rs1_addr = r_id_rs1;
  assign id_rs2_addr = r_id_rs2;
  assign id_rd_addr  = r_id_rd;
  assign id_alu_fn   = r_id_alu_fn;
  assign id_rs1_sel  = r_id_rs1_sel;
  assign id_rs2_sel  = r_id_rs2_sel;
  assign id_mem_wen  = r_id_mem_wen;
  assign id_wb_sel   = r_id_wb_sel;
  assign id_br       = r_id_br;
  assign id_illegal  = r_id_illegal;
  assign ibuf_count  = w_count;

endmodule
